// File: rtl/fx_bus_pkg.sv
// Shared definitions for the fx register bus: widths, device field, arbiter states, device IDs.
package fx_bus_pkg;

  localparam int unsigned FX_AW      = 22;
  localparam int unsigned FX_DW      = 8;
  localparam int unsigned FX_DEV_MSB = 21;
  localparam int unsigned FX_DEV_LSB = 16;
  localparam int unsigned FX_DEV_W   = FX_DEV_MSB - FX_DEV_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_RDCAP  = 3'd4
  } fx_state_e;

  localparam logic [FX_DEV_W-1:0] FX_DEV_CFG = 6'h01;
  localparam logic [FX_DEV_W-1:0] FX_DEV_ACQ = 6'h03;
  localparam logic [FX_DEV_W-1:0] FX_DEV_USB = 6'h04;

  // Device field of an fx address, as decoded by every slave.
  function automatic logic [FX_DEV_W-1:0] fx_dev(input logic [FX_AW-1:0] addr);
    return addr[FX_DEV_MSB:FX_DEV_LSB];
  endfunction

endpackage

// File: rtl/fx_bus_arb_if.sv
// Requester-side and fx-bus-side signals of the fx bus arbiter.
interface fx_bus_arb_if
  import fx_bus_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = FX_AW,
  parameter int unsigned DW   = FX_DW
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;
  logic [AW-1:0]      fx_waddr;
  logic [DW-1:0]      fx_data;
  logic               fx_wr;
  logic [AW-1:0]      fx_raddr;
  logic               fx_rd;
  logic [DW-1:0]      fx_q;
  logic               busy;

  modport master (
    input  req, req_we, req_addr, req_wdata, fx_q,
    output gnt, rd_valid, rd_data, fx_waddr, fx_data, fx_wr, fx_raddr, fx_rd, busy
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, fx_q,
    input  gnt, rd_valid, rd_data, fx_waddr, fx_data, fx_wr, fx_raddr, fx_rd, busy
  );

endinterface

// File: rtl/fx_rr_arb.sv
// Round-robin winner selection: search starts just after the last winner, pointer moves on advance.
module fx_rr_arb #(
  parameter int unsigned NREQ = 2
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant_c,
  output logic [$clog2(NREQ)-1:0] win_idx_c,
  output logic                    any_c
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;

  always_comb begin
    grant_c   = '0;
    win_idx_c = '0;
    any_c     = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(last_q) + k) % NREQ;
      if (!any_c && req[IW'(idx)]) begin
        any_c     = 1'b1;
        win_idx_c = IW'(idx);
      end
    end
    if (any_c) grant_c[win_idx_c] = 1'b1;
    last_d = (advance && any_c) ? win_idx_c : last_q;
  end

  // Reset to NREQ-1 so requester 0 wins the first contention.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) last_q <= IW'(NREQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/fx_bus_arb.sv
// Shares the fx register bus between NREQ requesters; one single-byte write or read at a time.
module fx_bus_arb
  import fx_bus_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = FX_AW,
  parameter int unsigned DW   = FX_DW
) (
  input logic          clk_sys,
  input logic          rst_n,
  fx_bus_arb_if.master bus
);

  localparam int unsigned IW = $clog2(NREQ);

  fx_state_e state_q, state_d;

  logic [NREQ-1:0] grant_c;
  logic [IW-1:0]   win_idx_c;
  logic            any_req_c;
  logic            advance_c;

  logic [IW-1:0]   win_q, win_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [AW-1:0]   fx_waddr_q, fx_waddr_d;
  logic [DW-1:0]   fx_data_q, fx_data_d;
  logic            fx_wr_q, fx_wr_d;
  logic [AW-1:0]   fx_raddr_q, fx_raddr_d;
  logic            fx_rd_q, fx_rd_d;
  logic            busy_q, busy_d;

  fx_rr_arb #(.NREQ(NREQ)) u_rr (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .req       (bus.req),
    .advance   (advance_c),
    .grant_c   (grant_c),
    .win_idx_c (win_idx_c),
    .any_c     (any_req_c)
  );

  // Outputs are registered, so each state drives what becomes visible one cycle later.
  always_comb begin
    state_d    = state_q;
    advance_c  = 1'b0;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_d      = '0;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    fx_waddr_d = fx_waddr_q;
    fx_data_d  = fx_data_q;
    fx_wr_d    = 1'b0;
    fx_raddr_d = fx_raddr_q;
    fx_rd_d    = 1'b0;
    busy_d     = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          advance_c = 1'b1;
          gnt_d     = grant_c;
          win_d     = win_idx_c;
          we_d      = bus.req_we[win_idx_c];
          addr_d    = bus.req_addr[32'(win_idx_c) * AW +: AW];
          wdata_d   = bus.req_wdata[32'(win_idx_c) * DW +: DW];
          state_d   = bus.req_we[win_idx_c] ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        fx_wr_d    = 1'b1;
        fx_waddr_d = addr_q;
        fx_data_d  = wdata_q;
        state_d    = ST_IDLE;
      end
      ST_RD: begin
        fx_rd_d    = 1'b1;
        fx_raddr_d = addr_q;
        state_d    = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        state_d = ST_RDCAP;
      end
      ST_RDCAP: begin
        rd_data_d         = bus.fx_q;
        rd_valid_d[win_q] = 1'b1;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      fx_waddr_q <= '0;
      fx_data_q  <= '0;
      fx_wr_q    <= 1'b0;
      fx_raddr_q <= '0;
      fx_rd_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      fx_waddr_q <= fx_waddr_d;
      fx_data_q  <= fx_data_d;
      fx_wr_q    <= fx_wr_d;
      fx_raddr_q <= fx_raddr_d;
      fx_rd_q    <= fx_rd_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.fx_waddr = fx_waddr_q;
  assign bus.fx_data  = fx_data_q;
  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_raddr = fx_raddr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Self-checking bench for fx_bus_arb: two requesters, a CFG slave model and a grant/data scoreboard.
module tb_fx_bus_arb;
  import fx_bus_pkg::*;

  localparam int unsigned NR = 2;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  fx_bus_arb_if #(.NREQ(NR), .AW(22), .DW(8)) bus ();

  fx_bus_arb #(.NREQ(NR), .AW(22), .DW(8)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  logic        r_req   [NR];
  logic        r_we    [NR];
  logic [21:0] r_addr  [NR];
  logic [7:0]  r_wdata [NR];

  assign bus.req       = {r_req[1], r_req[0]};
  assign bus.req_we    = {r_we[1], r_we[0]};
  assign bus.req_addr  = {r_addr[1], r_addr[0]};
  assign bus.req_wdata = {r_wdata[1], r_wdata[0]};

  // Slave model: CFG device with 16 registers at offsets 0x80..0x8F, other CFG offsets read 0x55.
  logic [7:0] slv_q;
  logic [7:0] cfg_mem [16];
  always @(posedge clk_sys) begin
    if (bus.fx_wr && fx_dev(bus.fx_waddr) == FX_DEV_CFG && bus.fx_waddr[15:4] == 12'h008)
      cfg_mem[bus.fx_waddr[3:0]] <= bus.fx_data;
    if (bus.fx_rd) begin
      if (fx_dev(bus.fx_raddr) != FX_DEV_CFG)    slv_q <= 8'h00;
      else if (bus.fx_raddr[15:4] == 12'h008)    slv_q <= cfg_mem[bus.fx_raddr[3:0]];
      else                                       slv_q <= 8'h55;
    end else begin
      slv_q <= 8'h00;
    end
  end
  assign bus.fx_q = slv_q;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int last_wr_cyc = 0;
  bit b2b_mode = 1'b0;

  int          exp_gnt     [$];
  logic [21:0] exp_waddr   [$];
  logic [7:0]  exp_wdata   [$];
  logic [21:0] exp_raddr   [$];
  int          exp_rd_req  [$];
  logic [7:0]  exp_rd_data [$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, 32'({bus.gnt, bus.rd_valid, bus.rd_data, bus.fx_wr, bus.fx_rd, bus.busy}), 32'h0);
    chk({tag, "_waddr"}, 32'(bus.fx_waddr), 32'h0);
    chk({tag, "_raddr"}, 32'(bus.fx_raddr), 32'h0);
    chk({tag, "_wdata"}, 32'(bus.fx_data), 32'h0);
  endtask

  task automatic push_wr(input int r, input logic [21:0] a, input logic [7:0] d);
    exp_gnt.push_back(r);
    exp_waddr.push_back(a);
    exp_wdata.push_back(d);
  endtask

  task automatic push_rd(input int r, input logic [21:0] a, input logic [7:0] d);
    exp_gnt.push_back(r);
    exp_raddr.push_back(a);
    exp_rd_req.push_back(r);
    exp_rd_data.push_back(d);
  endtask

  // Raise a request and hold it until its grant is seen, then drop it.
  task automatic do_req(input int r, input logic we, input logic [21:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    r_req[r] = 1'b1; r_we[r] = we; r_addr[r] = a; r_wdata[r] = d;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_sys);
      if (bus.gnt[1'(r)]) got = 1'b1;
    end
    r_req[r] = 1'b0;
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_sys);
      if (!bus.busy && exp_gnt.size() == 0 && exp_waddr.size() == 0 &&
          exp_raddr.size() == 0 && exp_rd_req.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk_sys);
  endtask

  // Output monitor: every grant, strobe and read return is checked against the scoreboard.
  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (bus.gnt != '0) begin
        chk("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
        else chk("gnt_who", 32'(bus.gnt), 32'd1 << exp_gnt.pop_front());
        gnt_cyc = cyc;
      end
      if (bus.fx_wr) begin
        chk("wr_rd_excl", 32'(bus.fx_rd), 32'd0);
        chk("wr_latency", 32'(cyc - gnt_cyc), 32'd1);
        if (b2b_mode && last_wr_cyc != 0) chk("wr_gap", 32'(cyc - last_wr_cyc), 32'd2);
        last_wr_cyc = cyc;
        if (exp_waddr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          chk("wr_addr", 32'(bus.fx_waddr), 32'(exp_waddr.pop_front()));
          chk("wr_data", 32'(bus.fx_data), 32'(exp_wdata.pop_front()));
        end
      end
      if (bus.fx_rd) begin
        chk("rd_latency", 32'(cyc - gnt_cyc), 32'd1);
        if (exp_raddr.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_addr", 32'(bus.fx_raddr), 32'(exp_raddr.pop_front()));
      end
      if (bus.rd_valid != '0) begin
        chk("rdv_onehot", 32'($onehot(bus.rd_valid)), 32'd1);
        chk("rdv_latency", 32'(cyc - gnt_cyc), 32'd3);
        if (exp_rd_req.size() == 0) chk("rdv_unexpected", 32'(bus.rd_valid), 32'd0);
        else begin
          chk("rdv_who", 32'(bus.rd_valid), 32'd1 << exp_rd_req.pop_front());
          chk("rd_data", 32'(bus.rd_data), 32'(exp_rd_data.pop_front()));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(NR); i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    for (int i = 0; i < 16; i++) cfg_mem[i] = 8'h00;
    slv_q = 8'h00;

    repeat (3) @(negedge clk_sys);
    chk_rst("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Single write then read-back from requester 0.
    push_wr(0, 22'h010083, 8'hA5);
    do_req(0, 1'b1, 22'h010083, 8'hA5);
    wait_idle();
    push_rd(0, 22'h010083, 8'hA5);
    do_req(0, 1'b0, 22'h010083, 8'h00);
    wait_idle();

    // Unmapped offset on a mapped device, then an absent device.
    push_rd(0, 22'h010090, 8'h55);
    do_req(0, 1'b0, 22'h010090, 8'h00);
    push_rd(1, 22'h020080, 8'h00);
    do_req(1, 1'b0, 22'h020080, 8'h00);
    wait_idle();

    // Both requesters held: grants must alternate 0,1,0,1.
    push_wr(0, 22'h010080, 8'h11);
    push_wr(1, 22'h010081, 8'h22);
    push_wr(0, 22'h010082, 8'h33);
    push_wr(1, 22'h010084, 8'h44);
    fork
      begin
        do_req(0, 1'b1, 22'h010080, 8'h11);
        do_req(0, 1'b1, 22'h010082, 8'h33);
      end
      begin
        do_req(1, 1'b1, 22'h010081, 8'h22);
        do_req(1, 1'b1, 22'h010084, 8'h44);
      end
    join
    wait_idle();

    // Back-to-back writes from requester 1: strobe every other cycle.
    b2b_mode = 1'b1;
    last_wr_cyc = 0;
    for (int i = 0; i < 8; i++) push_wr(1, 22'h010080 + 22'(i), 8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) do_req(1, 1'b1, 22'h010080 + 22'(i), 8'h80 + 8'(i));
    wait_idle();
    b2b_mode = 1'b0;

    // Requester 1 withdraws before being granted while requester 0 reads.
    push_rd(0, 22'h010085, 8'h85);
    fork
      do_req(0, 1'b0, 22'h010085, 8'h00);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
          @(negedge clk_sys);
          if (bus.gnt[0]) seen = 1'b1;
        end
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 22'h010086; r_wdata[1] = 8'hEE;
        repeat (2) @(negedge clk_sys);
        r_req[1] = 1'b0;
      end
    join
    wait_idle();
    repeat (6) @(negedge clk_sys);

    // Reset during the capture wait: outputs clear, the pending return is dropped.
    push_rd(0, 22'h010081, 8'h22);
    do_req(0, 1'b0, 22'h010081, 8'h00);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b0;
    exp_rd_req.delete();
    exp_rd_data.delete();
    @(negedge clk_sys);
    chk_rst("mid_reset");
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_sys);
    push_rd(0, 22'h010083, 8'h83);
    do_req(0, 1'b0, 22'h010083, 8'h00);
    wait_idle();

    chk("leftover_expect", 32'(exp_gnt.size() + exp_waddr.size() + exp_raddr.size() + exp_rd_req.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
